// File: rtl/ws2812b_pkg.sv
// Shared encodings for the WS2812b capture sequencer: FSM states,
// register addresses, status bit positions and the wire-to-bank slot map.
package ws2812b_pkg;

  localparam int WS_MAX_PIX = 4;
  localparam int WS_CNT_W   = 8;

  localparam logic [2:0] ST_WAIT    = 3'd0;
  localparam logic [2:0] ST_SKIP    = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_FORWARD = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [3:0] ADDR_SKIP = 4'hC;
  localparam logic [3:0] ADDR_CFG  = 4'hD;
  localparam logic [3:0] ADDR_CLR  = 4'hE;
  localparam logic [3:0] ADDR_STAT = 4'hF;

  localparam int STAT_READY   = 7;
  localparam int STAT_OVERRUN = 6;
  localparam int STAT_SHORT   = 5;
  localparam int STAT_ABSORB  = 4;

  // Wire order within a pixel is G,R,B; the bank stores R,G,B.
  function automatic logic [1:0] wire_slot(input logic [1:0] byte_idx);
    case (byte_idx)
      2'd0:    return 2'd1;
      2'd1:    return 2'd0;
      default: return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/ws2812b_pixel_bank.sv
// Shadow bank filled during capture and CPU-visible bank loaded on commit.
module ws2812b_pixel_bank
  import ws2812b_pkg::*;
#(
  parameter int MAX_PIX = WS_MAX_PIX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       commit,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam int         DEPTH   = 3 * MAX_PIX;
  localparam logic [3:0] DEPTH_A = 4'(DEPTH);

  logic [7:0] shadow_q  [DEPTH];
  logic [7:0] shadow_d  [DEPTH];
  logic [7:0] visible_q [DEPTH];
  logic [7:0] visible_d [DEPTH];

  // Next-state for both banks: byte write into shadow, whole-bank copy on commit.
  always_comb begin
    shadow_d  = shadow_q;
    visible_d = visible_q;
    if (wr_en && (wr_addr < DEPTH_A)) shadow_d[wr_addr] = wr_data;
    if (commit) visible_d = shadow_q;
  end

  // Bank storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '{default: '0};
      visible_q <= '{default: '0};
    end else begin
      shadow_q  <= shadow_d;
      visible_q <= visible_d;
    end
  end

  // CPU read port on the visible bank.
  always_comb begin
    rd_data = 8'h00;
    if (rd_addr < DEPTH_A) rd_data = visible_q[rd_addr];
  end

endmodule

// File: rtl/ws2812b_frame_sequencer.sv
// Frame sequencer: skips SKIP pixels, captures COUNT pixels into the shadow
// bank, commits on frame end and drives the per-byte forward gate.
//
// state   | meaning
// WAIT    | between frames, staging config is live, next byte starts a frame
// SKIP    | leading pixels forwarded, not captured
// CAPTURE | pixel bytes written to the shadow bank
// FORWARD | remaining bytes pass through, only counted
// DONE    | one cycle after idle: commit if capture completed
module ws2812b_frame_sequencer
  import ws2812b_pkg::*;
#(
  parameter int MAX_PIX = WS_MAX_PIX,
  parameter int CNT_W   = WS_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       idle,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       fwd_en,
  output logic       frame_ready
);

  localparam logic [CNT_W-1:0] PIX_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] PIX_MAX   = '1;
  localparam logic [2:0]       COUNT_MAX = 3'(MAX_PIX);

  function automatic logic [2:0] clamp_count(input logic [2:0] c);
    return (c > COUNT_MAX) ? COUNT_MAX : c;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [1:0]       bip_q, bip_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic [CNT_W-1:0] skip_stg_q, skip_stg_d, skip_act_q, skip_act_d;
  logic [2:0]       count_stg_q, count_stg_d, count_act_q, count_act_d;
  logic             absorb_stg_q, absorb_stg_d, absorb_act_q, absorb_act_d;
  logic             complete_q, complete_d;
  logic             fwd_en_q, fwd_en_d;
  logic             ready_q, ready_d;
  logic             overrun_q, overrun_d;
  logic             short_q, short_d;

  logic [2:0]       eff_state, next_state;
  logic [CNT_W-1:0] skip_sel, cap_idx, pix_next;
  logic [2:0]       count_sel;
  logic             absorb_sel;
  logic             wr_en, commit;
  logic [3:0]       wr_addr, wr_idx;
  logic [7:0]       bank_rd;

  // FSM, counters, config staging, flags and forward gate.
  always_comb begin
    state_d      = state_q;
    bip_d        = bip_q;
    pix_d        = pix_q;
    skip_stg_d   = skip_stg_q;
    count_stg_d  = count_stg_q;
    absorb_stg_d = absorb_stg_q;
    skip_act_d   = skip_act_q;
    count_act_d  = count_act_q;
    absorb_act_d = absorb_act_q;
    complete_d   = complete_q;
    fwd_en_d     = fwd_en_q;
    ready_d      = ready_q;
    overrun_d    = overrun_q;
    short_d      = short_q;
    wr_en        = 1'b0;
    wr_idx       = 4'd0;
    wr_addr      = 4'd0;
    commit       = 1'b0;
    eff_state    = state_q;
    next_state   = state_q;
    pix_next     = pix_q;

    // The frame decision in WAIT sees the staged config it is about to latch.
    skip_sel   = (state_q == ST_WAIT) ? skip_stg_q : skip_act_q;
    count_sel  = (state_q == ST_WAIT) ? clamp_count(count_stg_q) : count_act_q;
    absorb_sel = (state_q == ST_WAIT) ? absorb_stg_q : absorb_act_q;
    cap_idx    = pix_q - skip_sel;

    if (data_write) begin
      case (address)
        ADDR_SKIP: skip_stg_d = CNT_W'(data_in);
        ADDR_CFG: begin
          absorb_stg_d = data_in[7];
          count_stg_d  = data_in[2:0];
        end
        ADDR_CLR: begin
          if (data_in[7]) ready_d   = 1'b0;
          if (data_in[6]) overrun_d = 1'b0;
          if (data_in[5]) short_d   = 1'b0;
        end
        default: ;
      endcase
    end

    if (state_q == ST_DONE) begin
      commit     = complete_q;
      if (complete_q) begin
        ready_d = 1'b1;
        if (ready_q) overrun_d = 1'b1;
      end
      complete_d = 1'b0;
      bip_d      = 2'd0;
      pix_d      = '0;
      state_d    = ST_WAIT;
    end else if (idle) begin
      if (state_q == ST_CAPTURE) short_d = 1'b1;
      state_d = ST_DONE;
    end else if (byte_valid) begin
      if (state_q == ST_WAIT) begin
        skip_act_d   = skip_stg_q;
        count_act_d  = clamp_count(count_stg_q);
        absorb_act_d = absorb_stg_q;
        if (skip_sel != '0)       eff_state = ST_SKIP;
        else if (count_sel != '0) eff_state = ST_CAPTURE;
        else                      eff_state = ST_FORWARD;
      end
      if (bip_q == 2'd2) begin
        bip_d    = 2'd0;
        pix_next = (pix_q == PIX_MAX) ? pix_q : pix_q + PIX_ONE;
      end else begin
        bip_d    = bip_q + 2'd1;
      end
      pix_d      = pix_next;
      next_state = eff_state;
      if (eff_state == ST_CAPTURE) begin
        wr_en   = 1'b1;
        wr_idx  = 4'(cap_idx);
        wr_addr = wr_idx * 4'd3 + {2'b00, wire_slot(bip_q)};
        if ((bip_q == 2'd2) && ((cap_idx + PIX_ONE) == CNT_W'(count_sel))) begin
          next_state = ST_FORWARD;
          complete_d = 1'b1;
        end
      end
      if ((eff_state == ST_SKIP) && (pix_next == skip_sel))
        next_state = (count_sel != '0) ? ST_CAPTURE : ST_FORWARD;
      state_d  = next_state;
      fwd_en_d = !((next_state == ST_CAPTURE) && absorb_sel);
    end

    // Between frames the gate tracks the config the next frame will use.
    if (state_d == ST_WAIT)
      fwd_en_d = !absorb_stg_q || (clamp_count(count_stg_q) == 3'd0) || (skip_stg_q != '0);
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_WAIT;
      bip_q        <= 2'd0;
      pix_q        <= '0;
      skip_stg_q   <= '0;
      count_stg_q  <= 3'd1;
      absorb_stg_q <= 1'b1;
      skip_act_q   <= '0;
      count_act_q  <= 3'd1;
      absorb_act_q <= 1'b1;
      complete_q   <= 1'b0;
      fwd_en_q     <= 1'b0;
      ready_q      <= 1'b0;
      overrun_q    <= 1'b0;
      short_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      bip_q        <= bip_d;
      pix_q        <= pix_d;
      skip_stg_q   <= skip_stg_d;
      count_stg_q  <= count_stg_d;
      absorb_stg_q <= absorb_stg_d;
      skip_act_q   <= skip_act_d;
      count_act_q  <= count_act_d;
      absorb_act_q <= absorb_act_d;
      complete_q   <= complete_d;
      fwd_en_q     <= fwd_en_d;
      ready_q      <= ready_d;
      overrun_q    <= overrun_d;
      short_q      <= short_d;
    end
  end

  ws2812b_pixel_bank #(.MAX_PIX(MAX_PIX)) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (byte_data),
    .commit  (commit),
    .rd_addr (address),
    .rd_data (bank_rd)
  );

  // CPU read mux.
  always_comb begin
    case (address)
      ADDR_SKIP: data_out = 8'(skip_stg_q);
      ADDR_CFG:  data_out = {absorb_stg_q, 4'b0000, count_stg_q};
      ADDR_CLR:  data_out = 8'h00;
      ADDR_STAT: data_out = {ready_q, overrun_q, short_q, absorb_act_q, 1'b0, state_q};
      default:   data_out = bank_rd;
    endcase
  end

  assign fwd_en      = fwd_en_q;
  assign frame_ready = ready_q;

endmodule
